// File: rtl/lab4_net_net_endpoint_if.sv
// Header type and endpoint bundle for lab4_net_net_endpoint.
// The endpoint uses the slave modport; the client/router side uses master.
package lab4_net_net_endpoint_pkg;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned OPQ_W = 8;

  typedef struct packed {
    logic [ID_W-1:0]  dest;
    logic [ID_W-1:0]  src;
    logic [OPQ_W-1:0] opaque;
  } net_hdr_t;
endpackage

interface lab4_net_net_endpoint_if #(
  parameter int unsigned p_payload_nbits = 32
);
  import lab4_net_net_endpoint_pkg::*;

  logic [ID_W-1:0]            node_id;
  logic [ID_W-1:0]            tx_dest;
  logic [p_payload_nbits-1:0] tx_payload;
  logic                       tx_val;
  logic                       tx_rdy;
  net_hdr_t                   net_out_msg_hdr;
  logic [p_payload_nbits-1:0] net_out_msg_payload;
  logic                       net_out_val;
  logic                       net_out_rdy;
  net_hdr_t                   net_in_msg_hdr;
  logic [p_payload_nbits-1:0] net_in_msg_payload;
  logic                       net_in_val;
  logic                       net_in_rdy;
  logic [ID_W-1:0]            rx_src;
  logic [OPQ_W-1:0]           rx_opaque;
  logic [p_payload_nbits-1:0] rx_payload;
  logic                       rx_val;
  logic                       rx_rdy;
  logic                       seq_err;
  logic [7:0]                 err_count;

  modport slave (
    input  node_id, tx_dest, tx_payload, tx_val, net_out_rdy,
    input  net_in_msg_hdr, net_in_msg_payload, net_in_val, rx_rdy,
    output tx_rdy, net_out_msg_hdr, net_out_msg_payload, net_out_val,
    output net_in_rdy, rx_src, rx_opaque, rx_payload, rx_val,
    output seq_err, err_count
  );

  modport master (
    output node_id, tx_dest, tx_payload, tx_val, net_out_rdy,
    output net_in_msg_hdr, net_in_msg_payload, net_in_val, rx_rdy,
    input  tx_rdy, net_out_msg_hdr, net_out_msg_payload, net_out_val,
    input  net_in_rdy, rx_src, rx_opaque, rx_payload, rx_val,
    input  seq_err, err_count
  );
endinterface

// File: rtl/lab4_net_net_endpoint.sv
// Network endpoint: 2-deep TX/RX FIFOs, per-destination sequence tagging.
// Optional receive sequence checking is enabled by LAB4_NET_SEQ_CHECK_EN.
module lab4_net_net_endpoint
  import lab4_net_net_endpoint_pkg::*;
#(
  parameter int unsigned p_payload_nbits = 32
) (
  input logic                     clk,
  input logic                     reset,
  lab4_net_net_endpoint_if.slave  ep
);
  localparam int unsigned PW    = p_payload_nbits;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned NODES = 4;

  typedef struct packed {
    net_hdr_t      hdr;
    logic [PW-1:0] payload;
  } msg_t;

  msg_t             tx_mem_q [2];
  msg_t             tx_mem_d [2];
  logic             tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic             tx_rdy_q, tx_rdy_d, tx_val_q, tx_val_d;
  logic [OPQ_W-1:0] tx_seq_q [NODES];
  logic [OPQ_W-1:0] tx_seq_d [NODES];

  msg_t             rx_mem_q [2];
  msg_t             rx_mem_d [2];
  logic             rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic             rx_rdy_q, rx_rdy_d, rx_val_q, rx_val_d;

  logic tx_fire, tx_deq, rx_fire, rx_deq;
  msg_t tx_new;

  // Ready/valid flops hold the post-update FIFO state, so they read 0 under reset.
  always_comb begin
    tx_fire = ep.tx_val & tx_rdy_q;
    tx_deq  = tx_val_q & ep.net_out_rdy;
    tx_new.hdr.dest   = ep.tx_dest;
    tx_new.hdr.src    = ep.node_id;
    tx_new.hdr.opaque = tx_seq_q[ep.tx_dest];
    tx_new.payload    = ep.tx_payload;

    tx_mem_d = tx_mem_q;
    tx_seq_d = tx_seq_q;
    tx_wr_d  = tx_wr_q ^ tx_fire;
    tx_rd_d  = tx_rd_q ^ tx_deq;
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_fire) - CNT_W'(tx_deq);
    if (tx_fire) begin
      tx_mem_d[tx_wr_q]      = tx_new;
      tx_seq_d[ep.tx_dest]   = tx_seq_q[ep.tx_dest] + 8'd1;
    end
    tx_rdy_d = (tx_cnt_d != 2'd2);
    tx_val_d = (tx_cnt_d != 2'd0);
  end

  always_comb begin
    rx_fire = ep.net_in_val & rx_rdy_q;
    rx_deq  = rx_val_q & ep.rx_rdy;

    rx_mem_d = rx_mem_q;
    rx_wr_d  = rx_wr_q ^ rx_fire;
    rx_rd_d  = rx_rd_q ^ rx_deq;
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_fire) - CNT_W'(rx_deq);
    if (rx_fire) begin
      rx_mem_d[rx_wr_q].hdr     = ep.net_in_msg_hdr;
      rx_mem_d[rx_wr_q].payload = ep.net_in_msg_payload;
    end
    rx_rdy_d = (rx_cnt_d != 2'd2);
    rx_val_d = (rx_cnt_d != 2'd0);
  end

  // Storage needs no reset: occupancy counters gate every use of it.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q  <= 1'b0;
      tx_rd_q  <= 1'b0;
      tx_cnt_q <= '0;
      tx_rdy_q <= 1'b0;
      tx_val_q <= 1'b0;
      rx_wr_q  <= 1'b0;
      rx_rd_q  <= 1'b0;
      rx_cnt_q <= '0;
      rx_rdy_q <= 1'b0;
      rx_val_q <= 1'b0;
      for (int i = 0; i < NODES; i++) tx_seq_q[i] <= '0;
    end else begin
      tx_wr_q  <= tx_wr_d;
      tx_rd_q  <= tx_rd_d;
      tx_cnt_q <= tx_cnt_d;
      tx_rdy_q <= tx_rdy_d;
      tx_val_q <= tx_val_d;
      rx_wr_q  <= rx_wr_d;
      rx_rd_q  <= rx_rd_d;
      rx_cnt_q <= rx_cnt_d;
      rx_rdy_q <= rx_rdy_d;
      rx_val_q <= rx_val_d;
      tx_seq_q <= tx_seq_d;
    end
  end

`ifdef LAB4_NET_SEQ_CHECK_EN
  logic [OPQ_W-1:0] rx_exp_q [NODES];
  logic [OPQ_W-1:0] rx_exp_d [NODES];
  logic             seq_err_q, seq_err_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  // Resynchronise to the received opaque whether or not it matched.
  always_comb begin
    rx_exp_d  = rx_exp_q;
    seq_err_d = seq_err_q;
    err_cnt_d = err_cnt_q;
    if (rx_fire) begin
      if (ep.net_in_msg_hdr.opaque != rx_exp_q[ep.net_in_msg_hdr.src]) begin
        seq_err_d = 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end
      rx_exp_d[ep.net_in_msg_hdr.src] = ep.net_in_msg_hdr.opaque + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
      for (int i = 0; i < NODES; i++) rx_exp_q[i] <= '0;
    end else begin
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
      rx_exp_q  <= rx_exp_d;
    end
  end

  assign ep.seq_err   = seq_err_q;
  assign ep.err_count = err_cnt_q;
`else
  assign ep.seq_err   = 1'b0;
  assign ep.err_count = 8'd0;
`endif

  assign ep.tx_rdy              = tx_rdy_q;
  assign ep.net_out_val         = tx_val_q;
  assign ep.net_out_msg_hdr     = tx_mem_q[tx_rd_q].hdr;
  assign ep.net_out_msg_payload = tx_mem_q[tx_rd_q].payload;
  assign ep.net_in_rdy          = rx_rdy_q;
  assign ep.rx_val              = rx_val_q;
  assign ep.rx_src              = rx_mem_q[rx_rd_q].hdr.src;
  assign ep.rx_opaque           = rx_mem_q[rx_rd_q].hdr.opaque;
  assign ep.rx_payload          = rx_mem_q[rx_rd_q].payload;
endmodule
